// File: rtl/lut_ram_arbiter_pkg.sv
// rtl/lut_ram_arbiter_pkg.sv - shared types for the LUT RAM arbiter
package lut_ram_arbiter_pkg;

    // Host response FSM states
    typedef enum logic [1:0] {
        H_IDLE = 2'd0,
        H_PEND = 2'd1,
        H_HOLD = 2'd2
    } host_state_t;

    // Round-robin priority owner
    typedef enum logic {
        OWN_HOST = 1'b0,
        OWN_USER = 1'b1
    } owner_t;

endpackage

// File: rtl/lut_ram_arbiter_host_rsp.sv
// rtl/lut_ram_arbiter_host_rsp.sv - host read response FSM and held response register
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   rd_grant        host read granted on the RAM port this cycle
//   h_rready        host takes the held response
//   ram_rdata       RAM read data (valid the cycle after the grant)
//   host_can_issue  host may be granted a new request this cycle
//   h_rvalid        held host read response valid
//   h_rdata         held host read data
module lut_ram_arbiter_host_rsp
    import lut_ram_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rd_grant,
    input  logic                  h_rready,
    input  logic [DATA_WIDTH-1:0] ram_rdata,
    output logic                  host_can_issue,
    output logic                  h_rvalid,
    output logic [DATA_WIDTH-1:0] h_rdata
);

    host_state_t state;

    // A new request is only allowed when the response slot is empty or is
    // being emptied in this same cycle.
    assign host_can_issue = (state == H_IDLE) || ((state == H_HOLD) && h_rready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= H_IDLE;
            h_rvalid <= 1'b0;
            h_rdata  <= '0;
        end else begin
            case (state)
                H_IDLE: begin
                    if (rd_grant) state <= H_PEND;
                end
                H_PEND: begin
                    h_rdata  <= ram_rdata;
                    h_rvalid <= 1'b1;
                    state    <= H_HOLD;
                end
                H_HOLD: begin
                    if (h_rready) begin
                        h_rvalid <= 1'b0;
                        state    <= rd_grant ? H_PEND : H_IDLE;
                    end
                end
                default: begin
                    h_rvalid <= 1'b0;
                    state    <= H_IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/lut_ram_arbiter.sv
// rtl/lut_ram_arbiter.sv - round-robin arbiter sharing one LUT RAM port between host and user
//
// Ports:
//   clk, rst_n                               clock, asynchronous active-low reset
//   h_valid/h_ready/h_addr/h_we/h_wdata      host request (global address)
//   h_rvalid/h_rready/h_rdata                host read response, held until taken
//   u_valid/u_ready/u_addr/u_we/u_wdata      user request (local address)
//   u_rvalid/u_rdata                         one-cycle user read response
//   ram_en/ram_we/ram_addr/ram_wdata         RAM port, driven from the winner
//   ram_rdata                                RAM read data, one cycle after ram_en
//   conflict_cnt                             saturating count of contended cycles
module lut_ram_arbiter
    import lut_ram_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 16,
    parameter int DEPTH      = 256,
    parameter int BASE_ADDR  = 0,
    localparam int AW        = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  h_valid,
    output logic                  h_ready,
    input  logic [ADDR_WIDTH-1:0] h_addr,
    input  logic                  h_we,
    input  logic [DATA_WIDTH-1:0] h_wdata,
    output logic                  h_rvalid,
    input  logic                  h_rready,
    output logic [DATA_WIDTH-1:0] h_rdata,
    input  logic                  u_valid,
    output logic                  u_ready,
    input  logic [AW-1:0]         u_addr,
    input  logic                  u_we,
    input  logic [DATA_WIDTH-1:0] u_wdata,
    output logic                  u_rvalid,
    output logic [DATA_WIDTH-1:0] u_rdata,
    output logic                  ram_en,
    output logic                  ram_we,
    output logic [AW-1:0]         ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    input  logic [DATA_WIDTH-1:0] ram_rdata,
    output logic [15:0]           conflict_cnt
);

    localparam int                  AWX    = ADDR_WIDTH + 1;
    localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [AWX-1:0]      DEPTHX = AWX'(DEPTH);

    owner_t          prio;
    logic            host_can_issue;
    logic            in_range;
    logic [AWX-1:0]  offset;
    logic            h_elig;
    logic            u_elig;
    logic            grant_h;
    logic            grant_u;

    // Address decode; one extra bit keeps the subtraction from wrapping.
    assign offset   = {1'b0, h_addr} - {1'b0, BASE};
    assign in_range = (h_addr >= BASE) && (offset < DEPTHX);

    assign h_elig = h_valid && in_range && host_can_issue;
    assign u_elig = u_valid;

    // Grants are masked during reset so every output reads 0 while rst_n is low.
    assign grant_h = rst_n && h_elig && (!u_elig || (prio == OWN_HOST));
    assign grant_u = rst_n && u_elig && !grant_h;

    // Out-of-range host requests are swallowed at once without touching the RAM.
    assign h_ready = grant_h || (rst_n && h_valid && !in_range);
    assign u_ready = grant_u;

    always_comb begin
        ram_en    = grant_h || grant_u;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        if (grant_h) begin
            ram_we    = h_we;
            ram_addr  = offset[AW-1:0];
            ram_wdata = h_wdata;
        end else if (grant_u) begin
            ram_we    = u_we;
            ram_addr  = u_addr;
            ram_wdata = u_wdata;
        end
    end

    // The RAM's read register carries the data, so only the strobe is stored.
    assign u_rdata = u_rvalid ? ram_rdata : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio         <= OWN_HOST;
            u_rvalid     <= 1'b0;
            conflict_cnt <= '0;
        end else begin
            if (grant_h)      prio <= OWN_USER;
            else if (grant_u) prio <= OWN_HOST;
            u_rvalid <= grant_u && !u_we;
            if (h_elig && u_elig && (conflict_cnt != 16'hFFFF))
                conflict_cnt <= conflict_cnt + 16'd1;
        end
    end

    lut_ram_arbiter_host_rsp #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_host_rsp (
        .clk           (clk),
        .rst_n         (rst_n),
        .rd_grant      (grant_h && !h_we),
        .h_rready      (h_rready),
        .ram_rdata     (ram_rdata),
        .host_can_issue(host_can_issue),
        .h_rvalid      (h_rvalid),
        .h_rdata       (h_rdata)
    );

endmodule

// File: tb/tb_lut_ram_arbiter.sv
// tb/tb_lut_ram_arbiter.sv - directed self-checking bench for lut_ram_arbiter
module tb_lut_ram_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        h_valid = 1'b0, h_we = 1'b0, h_rready = 1'b0;
    logic [15:0] h_addr = '0, h_wdata = '0;
    logic        h_ready, h_rvalid;
    logic [15:0] h_rdata;
    logic        u_valid = 1'b0, u_we = 1'b0;
    logic [7:0]  u_addr = '0;
    logic [15:0] u_wdata = '0;
    logic        u_ready, u_rvalid;
    logic [15:0] u_rdata;
    logic        ram_en, ram_we;
    logic [7:0]  ram_addr;
    logic [15:0] ram_wdata, ram_rdata;
    logic [15:0] conflict_cnt;

    logic        pre_en = 1'b0;
    logic [7:0]  pre_addr = '0;
    logic [15:0] pre_data = '0;
    logic [15:0] mem [0:255];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Behavioural single-port RAM with one-cycle read and a bench preload port
    always @(posedge clk) begin
        if (pre_en) mem[pre_addr] <= pre_data;
        else if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            else        ram_rdata <= mem[ram_addr];
        end
    end

    lut_ram_arbiter #(
        .DATA_WIDTH(16), .ADDR_WIDTH(16), .DEPTH(256), .BASE_ADDR(0)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .h_valid(h_valid), .h_ready(h_ready), .h_addr(h_addr), .h_we(h_we), .h_wdata(h_wdata),
        .h_rvalid(h_rvalid), .h_rready(h_rready), .h_rdata(h_rdata),
        .u_valid(u_valid), .u_ready(u_ready), .u_addr(u_addr), .u_we(u_we), .u_wdata(u_wdata),
        .u_rvalid(u_rvalid), .u_rdata(u_rdata),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .conflict_cnt(conflict_cnt)
    );

    task automatic clear_inputs();
        h_valid = 0; h_we = 0; h_addr = '0; h_wdata = '0; h_rready = 1;
        u_valid = 0; u_we = 0; u_addr = '0; u_wdata = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 0;
        clear_inputs();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic preload(input logic [7:0] a, input logic [15:0] d);
        pre_en = 1; pre_addr = a; pre_data = d;
        @(negedge clk);
        pre_en = 0;
    endtask

    task automatic test_reset();
        rst_n = 0;
        h_valid = 1; h_addr = 16'h0001; u_valid = 1; u_addr = 8'h01;
        @(negedge clk);
        #1;
        checks++; if ({h_ready, u_ready, ram_en, ram_we} !== 4'b0) begin errors++;
            $display("FAIL reset_strobes got %b exp 0000", {h_ready, u_ready, ram_en, ram_we}); end
        checks++; if ({h_rvalid, u_rvalid} !== 2'b0) begin errors++;
            $display("FAIL reset_rvalid got %b exp 00", {h_rvalid, u_rvalid}); end
        checks++; if (conflict_cnt !== 16'd0) begin errors++;
            $display("FAIL reset_conflict got %h exp 0000", conflict_cnt); end
        checks++; if ({ram_addr, ram_wdata, h_rdata, u_rdata} !== 56'd0) begin errors++;
            $display("FAIL reset_data got %h exp 0", {ram_addr, ram_wdata, h_rdata, u_rdata}); end
        clear_inputs();
        preload(8'h05, 16'hBEEF);
        preload(8'h07, 16'h7777);
        preload(8'h09, 16'h9999);
        preload(8'h00, 16'h0F0F);
        rst_n = 1;
    endtask

    task automatic test_host_read();
        do_reset();
        h_valid = 1; h_addr = 16'h0005; h_we = 0; h_rready = 1;
        #1;
        checks++; if ({ram_en, ram_we, h_ready, ram_addr} !== {3'b101, 8'h05}) begin errors++;
            $display("FAIL hrd_grant got en=%b we=%b rdy=%b addr=%h exp 1 0 1 05", ram_en, ram_we, h_ready, ram_addr); end
        @(negedge clk);
        h_valid = 0;
        #1;
        checks++; if (h_rvalid !== 1'b0) begin errors++;
            $display("FAIL hrd_t1_rvalid got %b exp 0", h_rvalid); end
        @(negedge clk);
        #1;
        checks++; if (h_rvalid !== 1'b1 || h_rdata !== 16'hBEEF) begin errors++;
            $display("FAIL hrd_t2 got rvalid=%b data=%h exp 1 beef", h_rvalid, h_rdata); end
        @(negedge clk);
        #1;
        checks++; if (h_rvalid !== 1'b0) begin errors++;
            $display("FAIL hrd_t3_rvalid got %b exp 0", h_rvalid); end
    endtask

    task automatic test_round_robin();
        int hg = 0, ug = 0;
        do_reset();
        h_valid = 1; h_addr = 16'h0005; h_we = 0; h_rready = 1;
        u_valid = 1; u_addr = 8'h09; u_we = 0;
        for (int i = 0; i < 100; i++) begin
            #1;
            hg += int'(h_ready); ug += int'(u_ready);
            checks++; if ({h_ready, u_ready} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin errors++;
                $display("FAIL rr_grant cyc %0d got %b exp %b", i, {h_ready, u_ready}, (i % 2 == 0) ? 2'b10 : 2'b01); end
            if (i >= 2 && i % 2 == 0) begin
                checks++; if (u_rvalid !== 1'b1 || u_rdata !== 16'h9999 || h_rvalid !== 1'b1 || h_rdata !== 16'hBEEF) begin errors++;
                    $display("FAIL rr_rsp cyc %0d got u=%b/%h h=%b/%h exp 1/9999 1/beef", i, u_rvalid, u_rdata, h_rvalid, h_rdata); end
            end
            @(negedge clk);
        end
        checks++; if (conflict_cnt !== 16'd50) begin errors++;
            $display("FAIL rr_conflict got %0d exp 50", conflict_cnt); end
        checks++; if (hg != 50 || ug != 50) begin errors++;
            $display("FAIL rr_fairness got host=%0d user=%0d exp 50 50", hg, ug); end
        clear_inputs();
        repeat (3) @(negedge clk);
    endtask

    task automatic test_hold_stall();
        do_reset();
        h_valid = 1; h_addr = 16'h0007; h_we = 0; h_rready = 0;
        #1;
        checks++; if (h_ready !== 1'b1) begin errors++;
            $display("FAIL hold_first_grant got %b exp 1", h_ready); end
        @(negedge clk);
        h_valid = 0;
        @(negedge clk);
        for (int k = 0; k < 10; k++) begin
            h_valid = 1; h_addr = 16'h0005;
            u_valid = 1; u_we = 1; u_addr = 8'(10 + k); u_wdata = 16'h1234;
            #1;
            checks++; if ({u_ready, h_ready, h_rvalid} !== 3'b101 || h_rdata !== 16'h7777) begin errors++;
                $display("FAIL hold_stall k %0d got u_rdy=%b h_rdy=%b rvalid=%b data=%h exp 1 0 1 7777", k, u_ready, h_ready, h_rvalid, h_rdata); end
            @(negedge clk);
        end
        u_valid = 0; h_rready = 1;
        #1;
        checks++; if (h_ready !== 1'b1 || ram_addr !== 8'h05) begin errors++;
            $display("FAIL hold_release got rdy=%b addr=%h exp 1 05", h_ready, ram_addr); end
        @(negedge clk);
        h_valid = 0;
        #1;
        checks++; if (h_rvalid !== 1'b0) begin errors++;
            $display("FAIL hold_pend_rvalid got %b exp 0", h_rvalid); end
        @(negedge clk);
        #1;
        checks++; if (h_rvalid !== 1'b1 || h_rdata !== 16'hBEEF) begin errors++;
            $display("FAIL hold_second_rsp got %b/%h exp 1/beef", h_rvalid, h_rdata); end
        checks++; if (conflict_cnt !== 16'd0) begin errors++;
            $display("FAIL hold_conflict got %0d exp 0", conflict_cnt); end
        for (int k = 0; k < 10; k++) begin
            checks++; if (mem[10 + k] !== 16'h1234) begin errors++;
                $display("FAIL hold_user_write addr %0d got %h exp 1234", 10 + k, mem[10 + k]); end
        end
        @(negedge clk);
    endtask

    task automatic test_out_of_range();
        do_reset();
        h_valid = 1; h_we = 1; h_addr = 16'h0200; h_wdata = 16'hDEAD;
        u_valid = 1; u_we = 1; u_addr = 8'h08; u_wdata = 16'h5555;
        #1;
        checks++; if ({h_ready, u_ready, ram_en, ram_we} !== 4'b1111 || ram_addr !== 8'h08 || ram_wdata !== 16'h5555) begin errors++;
            $display("FAIL oor_both got %b addr=%h wdata=%h exp 1111 08 5555", {h_ready, u_ready, ram_en, ram_we}, ram_addr, ram_wdata); end
        @(negedge clk);
        clear_inputs();
        checks++; if (mem[8] !== 16'h5555 || mem[0] !== 16'h0F0F) begin errors++;
            $display("FAIL oor_ram got m8=%h m0=%h exp 5555 0f0f", mem[8], mem[0]); end
        checks++; if (conflict_cnt !== 16'd0) begin errors++;
            $display("FAIL oor_conflict got %0d exp 0", conflict_cnt); end
        for (int k = 0; k < 2; k++) begin
            #1;
            checks++; if (h_rvalid !== 1'b0) begin errors++;
                $display("FAIL oor_no_rsp got %b exp 0", h_rvalid); end
            @(negedge clk);
        end
        h_valid = 1; h_we = 0; h_addr = 16'h00FF;
        #1;
        checks++; if (h_ready !== 1'b1 || ram_en !== 1'b1 || ram_addr !== 8'hFF) begin errors++;
            $display("FAIL oor_top_word got rdy=%b en=%b addr=%h exp 1 1 ff", h_ready, ram_en, ram_addr); end
        @(negedge clk);
        h_addr = 16'h0100;
        #1;
        checks++; if (h_ready !== 1'b1 || ram_en !== 1'b0) begin errors++;
            $display("FAIL oor_first_out got rdy=%b en=%b exp 1 0", h_ready, ram_en); end
        @(negedge clk);
        clear_inputs();
        repeat (2) @(negedge clk);
    endtask

    task automatic test_write_then_read();
        do_reset();
        u_valid = 1; u_we = 1; u_addr = 8'h03; u_wdata = 16'h00AA;
        #1;
        checks++; if (u_ready !== 1'b1) begin errors++;
            $display("FAIL wr_rd_user_grant got %b exp 1", u_ready); end
        @(negedge clk);
        u_valid = 0; h_valid = 1; h_we = 0; h_addr = 16'h0003; h_rready = 1;
        #1;
        checks++; if (h_ready !== 1'b1) begin errors++;
            $display("FAIL wr_rd_host_grant got %b exp 1", h_ready); end
        @(negedge clk);
        h_valid = 0;
        @(negedge clk);
        #1;
        checks++; if (h_rvalid !== 1'b1 || h_rdata !== 16'h00AA) begin errors++;
            $display("FAIL wr_rd_data got %b/%h exp 1/00aa", h_rvalid, h_rdata); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        do_reset();
        h_valid = 1; h_we = 0; h_addr = 16'h0005; h_rready = 1;
        @(negedge clk);
        h_valid = 0; u_valid = 1; u_we = 0; u_addr = 8'h09;
        rst_n = 0;
        #1;
        checks++; if ({ram_en, u_ready, h_rvalid, u_rvalid} !== 4'b0 || conflict_cnt !== 16'd0) begin errors++;
            $display("FAIL mid_reset_outputs got %b cnt=%h exp 0000 0", {ram_en, u_ready, h_rvalid, u_rvalid}, conflict_cnt); end
        @(negedge clk);
        rst_n = 1; u_valid = 0;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++; if ({h_rvalid, u_rvalid} !== 2'b00) begin errors++;
                $display("FAIL mid_reset_no_rsp got %b exp 00", {h_rvalid, u_rvalid}); end
            @(negedge clk);
        end
        h_valid = 1; h_addr = 16'h0005; u_valid = 1;
        #1;
        checks++; if ({h_ready, u_ready} !== 2'b10) begin errors++;
            $display("FAIL mid_reset_prio got %b exp 10", {h_ready, u_ready}); end
        @(negedge clk);
        clear_inputs();
        repeat (3) @(negedge clk);
    endtask

    initial begin
        fork
            begin
                test_reset();
                test_host_read();
                test_round_robin();
                test_hold_stall();
                test_out_of_range();
                test_write_then_read();
                test_reset_mid();
            end
            begin
                #200000;
                errors++;
                $display("FAIL timeout got running exp finished");
            end
        join_any
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
